// File: rtl/game_pkg.sv
// Shared game-state encodings, pixel width and the per-channel saturating colour adder.
package game_pkg;

  localparam int unsigned PIX_W = 12;

  localparam logic [2:0] GS_WELCOME = 3'd0;
  localparam logic [2:0] GS_START   = 3'd1;
  localparam logic [2:0] GS_PLAY    = 3'd2;
  localparam logic [2:0] GS_PAUSE   = 3'd3;
  localparam logic [2:0] GS_FINISH  = 3'd4;

  // Adds two RGB444 pixels channel by channel, clamping each channel at 4'hF.
  function automatic logic [PIX_W-1:0] sat_add12(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    logic [4:0]       sum;
    logic [PIX_W-1:0] res;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      sum          = {1'b0, a[c*4 +: 4]} + {1'b0, b[c*4 +: 4]};
      res[c*4 +: 4] = sum[4] ? 4'hF : sum[3:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/layer_priority_mux.sv
// Combinational first-opaque select over the player layers; lower index wins.
module layer_priority_mux
  import game_pkg::*;
#(
  parameter int unsigned      NUM_LAYERS = 4,
  parameter logic [PIX_W-1:0] KEY        = 12'hFFF
) (
  input  logic [NUM_LAYERS-1:0][PIX_W-1:0] layer_pixel_i,
  input  logic [3:0]                       active_i,
  output logic [PIX_W-1:0]                 pixel_o,
  output logic                             valid_o
);

  // Walk from the highest index down so the lowest opaque index is the last writer.
  always_comb begin
    pixel_o = '0;
    valid_o = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if ((4'(i) < active_i) && (layer_pixel_i[i] != KEY)) begin
        pixel_o = layer_pixel_i[i];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Three-stage pixel compositor: input capture, layer priority/background, state overlay.
module layer_compositor
  import game_pkg::*;
#(
  parameter int unsigned      NUM_LAYERS   = 4,
  parameter int unsigned      NUM_INFO     = 4,
  parameter logic [PIX_W-1:0] KEY          = 12'hFFF,
  parameter int unsigned      BLINK_FRAMES = 30
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic [2:0]                       game_state_i,
  input  logic [3:0]                       num_active_i,
  input  logic [NUM_LAYERS-1:0][PIX_W-1:0] layer_pixel_i,
  input  logic [PIX_W-1:0]                 object_pixel_i,
  input  logic [PIX_W-1:0]                 floor_pixel_i,
  input  logic [NUM_INFO-1:0][PIX_W-1:0]   info_pixel_i,
  input  logic [PIX_W-1:0]                 banner_pixel_i,
  input  logic [10:0]                      hcount_i,
  input  logic [9:0]                       vcount_i,
  input  logic                             hsync_i,
  input  logic                             vsync_i,
  input  logic                             blank_i,
  output logic                             hsync_out_o,
  output logic                             vsync_out_o,
  output logic                             blank_out_o,
  output logic [PIX_W-1:0]                 pixel_out_o,
  output logic                             frame_tick_o
);

  localparam logic [3:0] MaxActive = 4'(NUM_LAYERS);
  localparam logic [7:0] BlinkLast = 8'(BLINK_FRAMES - 1);

  // Stage 1 registers
  logic [NUM_LAYERS-1:0][PIX_W-1:0] s1_layer_q;
  logic [NUM_INFO-1:0][PIX_W-1:0]   s1_info_q;
  logic [PIX_W-1:0] s1_obj_q, s1_floor_q, s1_banner_q;
  logic [10:0]      s1_h_q;
  logic [9:0]       s1_v_q;
  logic [2:0]       s1_state_q;
  logic             s1_hs_q, s1_vs_q, s1_blank_q;

  // Frame and blink state
  logic       frame_fall;
  logic [3:0] active_q, active_d;
  logic       tick_q;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;

  // Stage 2 / 3
  logic [PIX_W-1:0] mux_pix, bg_pix, s2_pix_d, s2_pix_q, s2_banner_q, pix_d, pix_q;
  logic             mux_valid, in_window;
  logic [2:0]       s2_state_q;
  logic             s2_blink_q, s2_hs_q, s2_vs_q, s2_blank_q;
  logic             hs_q, vs_q, blank_q;

  // s1_vs_q holds the previous vsync sample, so this is a falling edge on the incoming one.
  assign frame_fall = s1_vs_q & ~vsync_i;

  always_comb begin
    active_d = active_q;
    if (frame_fall) active_d = (num_active_i > MaxActive) ? MaxActive : num_active_i;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (game_state_i != GS_FINISH) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (frame_fall) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_layer_q  <= '0;
      s1_info_q   <= '0;
      s1_obj_q    <= '0;
      s1_floor_q  <= '0;
      s1_banner_q <= '0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      s1_state_q  <= GS_WELCOME;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      s1_blank_q  <= 1'b1;
      active_q    <= '0;
      tick_q      <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      s1_layer_q  <= layer_pixel_i;
      s1_info_q   <= info_pixel_i;
      s1_obj_q    <= object_pixel_i;
      s1_floor_q  <= floor_pixel_i;
      s1_banner_q <= banner_pixel_i;
      s1_h_q      <= hcount_i;
      s1_v_q      <= vcount_i;
      s1_state_q  <= game_state_i;
      s1_hs_q     <= hsync_i;
      s1_vs_q     <= vsync_i;
      s1_blank_q  <= blank_i;
      active_q    <= active_d;
      tick_q      <= frame_fall;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .KEY        (KEY)
  ) u_layer_priority_mux (
    .layer_pixel_i (s1_layer_q),
    .active_i      (active_q),
    .pixel_o       (mux_pix),
    .valid_o       (mux_valid)
  );

  assign in_window = (s1_h_q >= 11'd112) && (s1_h_q <= 11'd527) &&
                     (s1_v_q >= 10'd112) && (s1_v_q <= 10'd368);

  always_comb begin
    bg_pix = s1_floor_q;
    for (int k = 0; k < NUM_INFO; k++) bg_pix = sat_add12(bg_pix, s1_info_q[k]);
  end

  always_comb begin
    if (mux_valid)                        s2_pix_d = mux_pix;
    else if (in_window && s1_obj_q != KEY) s2_pix_d = s1_obj_q;
    else                                  s2_pix_d = bg_pix;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s2_pix_q    <= '0;
      s2_banner_q <= '0;
      s2_state_q  <= GS_WELCOME;
      s2_blink_q  <= 1'b1;
      s2_hs_q     <= 1'b1;
      s2_vs_q     <= 1'b1;
      s2_blank_q  <= 1'b1;
    end else begin
      s2_pix_q    <= s2_pix_d;
      s2_banner_q <= s1_banner_q;
      s2_state_q  <= s1_state_q;
      s2_blink_q  <= blink_on_q;
      s2_hs_q     <= s1_hs_q;
      s2_vs_q     <= s1_vs_q;
      s2_blank_q  <= s1_blank_q;
    end
  end

  // Unlisted state codes fall through to the default and behave as PLAY.
  always_comb begin
    pix_d = s2_pix_q;
    case (s2_state_q)
      GS_WELCOME: if (s2_banner_q != '0) pix_d = s2_banner_q;
      GS_PAUSE:   pix_d = (s2_pix_q >> 1) & 12'h777;
      GS_FINISH:  if (s2_banner_q != '0 && s2_blink_q) pix_d = s2_banner_q;
      default:    pix_d = s2_pix_q;
    endcase
    if (s2_blank_q) pix_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pix_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      pix_q   <= pix_d;
      hs_q    <= s2_hs_q;
      vs_q    <= s2_vs_q;
      blank_q <= s2_blank_q;
    end
  end

  assign pixel_out_o  = pix_q;
  assign hsync_out_o  = hs_q;
  assign vsync_out_o  = vs_q;
  assign blank_out_o  = blank_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised scoreboard bench for layer_compositor against a frame-level reference model.
module tb_layer_compositor;

  localparam int NL = 4;
  localparam int NI = 4;
  localparam int BF = 2;
  localparam logic [11:0] KEYC = 12'hFFF;

  logic                     clock_i = 1'b0;
  logic                     reset_i;
  logic [2:0]               gs;
  logic [3:0]               na;
  logic [NL-1:0][11:0]      lp;
  logic [NI-1:0][11:0]      ip;
  logic [11:0]              op, fp, bp;
  logic [10:0]              hc;
  logic [9:0]               vc;
  logic                     hs, vs, bl;
  logic                     hs_o, vs_o, bl_o, tick_o;
  logic [11:0]              pix_o;

  layer_compositor #(
    .NUM_LAYERS   (NL),
    .NUM_INFO     (NI),
    .KEY          (KEYC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .game_state_i   (gs),
    .num_active_i   (na),
    .layer_pixel_i  (lp),
    .object_pixel_i (op),
    .floor_pixel_i  (fp),
    .info_pixel_i   (ip),
    .banner_pixel_i (bp),
    .hcount_i       (hc),
    .vcount_i       (vc),
    .hsync_i        (hs),
    .vsync_i        (vs),
    .blank_i        (bl),
    .hsync_out_o    (hs_o),
    .vsync_out_o    (vs_o),
    .blank_out_o    (bl_o),
    .pixel_out_o    (pix_o),
    .frame_tick_o   (tick_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {int due; logic [11:0] pix; logic [2:0] syncs;} exp_t;
  typedef struct {int due; logic tick;} tick_t;
  exp_t  pq[$];
  tick_t tq[$];
  exp_t  me;
  tick_t mt;

  int neg_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: previous vsync, latched player count, FINISH frame count.
  int m_prev_vs, m_active, m_ff;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int chan(input logic [11:0] p, input int c);
    return int'((p >> (4 * c)) & 12'hF);
  endfunction

  // Called one time unit after a rising edge: records expectations for the sample taken at
  // the next rising edge, then waits past it.
  task automatic step();
    logic        fall;
    logic        found;
    logic        banner_on;
    logic [11:0] p;
    int          s;
    fall = (m_prev_vs == 1) && (vs == 1'b0);
    m_prev_vs = int'(vs);
    if (fall) m_active = (int'(na) > NL) ? NL : int'(na);
    if (gs != 3'd4) m_ff = 0;
    else if (fall) m_ff++;
    banner_on = ((m_ff / BF) % 2) == 0;

    found = 1'b0;
    p = '0;
    for (int i = 0; i < m_active; i++) begin
      if (!found && lp[i] != KEYC) begin
        p = lp[i];
        found = 1'b1;
      end
    end
    if (!found && hc >= 112 && hc <= 527 && vc >= 112 && vc <= 368 && op != KEYC) begin
      p = op;
      found = 1'b1;
    end
    if (!found) begin
      for (int c = 0; c < 3; c++) begin
        s = chan(fp, c);
        for (int k = 0; k < NI; k++) s += chan(ip[k], c);
        if (s > 15) s = 15;
        p = p | 12'(s << (4 * c));
      end
    end

    case (gs)
      3'd0: if (bp != 0) p = bp;
      3'd3: p = 12'((chan(p, 2) / 2) * 256 + (chan(p, 1) / 2) * 16 + chan(p, 0) / 2);
      3'd4: if (bp != 0 && banner_on) p = bp;
      default: ;
    endcase
    if (bl) p = '0;

    pq.push_back('{due: neg_cnt + 4, pix: p, syncs: {hs, vs, bl}});
    tq.push_back('{due: neg_cnt + 2, tick: fall});
    @(posedge clock_i);
    #1;
  endtask

  task automatic frame_pulse();
    vs = 1'b0;
    step();
    step();
    vs = 1'b1;
    step();
  endtask

  // Monitor: compares whatever the scoreboard says is due at this falling edge.
  always @(negedge clock_i) begin
    neg_cnt++;
    while (pq.size() > 0 && pq[0].due <= neg_cnt) begin
      me = pq.pop_front();
      chk("pixel_out", 32'(pix_o), 32'(me.pix));
      chk("hs_vs_blank_out", 32'({hs_o, vs_o, bl_o}), 32'(me.syncs));
    end
    while (tq.size() > 0 && tq[0].due <= neg_cnt) begin
      mt = tq.pop_front();
      chk("frame_tick", 32'(tick_o), 32'(mt.tick));
    end
  end

  initial begin
    int vcnt;
    reset_i = 1'b1;
    gs = 3'd2; na = 4'd0; lp = '0; ip = '0; op = '0; fp = '0; bp = '0;
    hc = '0; vc = '0; hs = 1'b1; vs = 1'b1; bl = 1'b1;
    m_prev_vs = 1; m_active = 0; m_ff = 0;
    repeat (3) @(posedge clock_i);
    #1;
    chk("reset_pixel", 32'(pix_o), 32'h0);
    chk("reset_syncs", 32'({hs_o, vs_o, bl_o}), 32'h7);
    chk("reset_tick", 32'(tick_o), 32'h0);
    reset_i = 1'b0;
    repeat (5) step();

    // Player layer priority with four active layers.
    bl = 1'b0; na = 4'd4;
    lp[0] = 12'hF00; lp[1] = 12'h0F0; lp[2] = KEYC; lp[3] = KEYC;
    frame_pulse();
    repeat (3) step();
    lp[0] = KEYC;
    repeat (3) step();

    // Mid-frame count change holds until the next frame.
    na = 4'd1;
    repeat (4) step();
    frame_pulse();
    repeat (3) step();

    // Saturating background outside the object window.
    hc = 11'd20; vc = 10'd20; op = 12'h123;
    fp = 12'h8A4; ip[0] = 12'h9A1;
    repeat (3) step();
    hc = 11'd112; vc = 10'd368;
    repeat (2) step();

    // Pause dimming.
    gs = 3'd3; lp[0] = 12'hF84;
    repeat (3) step();

    // Blink sequence, then leave and re-enter FINISH.
    gs = 3'd4; bp = 12'h00F; lp[0] = 12'h0A0;
    repeat (2) step();
    repeat (6) begin
      frame_pulse();
      repeat (3) step();
    end
    gs = 3'd2;
    frame_pulse();
    repeat (2) step();
    gs = 3'd4;
    repeat (3) step();
    frame_pulse();
    repeat (3) step();

    // Randomised traffic with periodic frames.
    vcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      vcnt++;
      vs = ((vcnt % 37) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 59) == 0) gs = 3'($urandom_range(0, 7));
      na = 4'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) lp[i] = ($urandom_range(0, 1) == 0) ? KEYC : 12'($urandom);
      for (int k = 0; k < NI; k++) ip[k] = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
      op = ($urandom_range(0, 2) == 0) ? KEYC : 12'($urandom);
      fp = 12'($urandom);
      bp = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
      case ($urandom_range(0, 5))
        0: hc = 11'd111;
        1: hc = 11'd112;
        2: hc = 11'd527;
        3: hc = 11'd528;
        default: hc = 11'($urandom_range(0, 1023));
      endcase
      case ($urandom_range(0, 5))
        0: vc = 10'd111;
        1: vc = 10'd112;
        2: vc = 10'd368;
        3: vc = 10'd369;
        default: vc = 10'($urandom_range(0, 767));
      endcase
      hs = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      bl = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      step();
    end

    repeat (8) @(posedge clock_i);
    #1;
    chk("scoreboard_drained", 32'(pq.size() + tq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
